// File: rtl/fir_tap_loader_pkg.sv
// fir_tap_loader_pkg: FSM state type and tap-count helper shared by the FIR tap loader.
package fir_tap_loader_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_DISABLE, ST_STREAM, ST_WAIT_DONE, ST_ERROR} state_t;
   function automatic int calc_num_taps(input int stages_log2, input int depth_log2);
      return 2 ** (stages_log2 + depth_log2);
   endfunction
endpackage

// File: rtl/fir_tap_loader_coef_mem.sv
// fir_tap_loader_coef_mem: shadow coefficient bank, one synchronous write port, asynchronous read.
// Ports: clk; wr_en_i/wr_addr_i/wr_data_i write port; rd_addr_i -> rd_data_o combinational read.
module fir_tap_loader_coef_mem #(
   parameter int G_DEPTH = 16,
   parameter int G_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       wr_en_i,
   input  logic [$clog2(G_DEPTH)-1:0] wr_addr_i,
   input  logic [G_WIDTH-1:0]         wr_data_i,
   input  logic [$clog2(G_DEPTH)-1:0] rd_addr_i,
   output logic [G_WIDTH-1:0]         rd_data_o
);
   logic [G_WIDTH-1:0] mem_q [G_DEPTH];
   always_ff @(posedge clk)
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: programs a configurable FIR by power-cycling its enable and streaming the coefficient bank.
// Ports: clk, reset (sync, active-high); cfg_wr_* coefficient writes with cfg_wr_reject while busy;
// load_start/reverse request a load; busy/load_done/load_error status; fir_enable, tap_dout* stream
// and tap_fir_done towards the FIR.
module fir_tap_loader
   import fir_tap_loader_pkg::*;
#(
   parameter int G_NUM_STAGES_LOG2  = 2,
   parameter int G_STAGE_DEPTH_LOG2 = 2,
   parameter int G_TAP_WIDTH        = 16,
   parameter int G_DISABLE_CYCLES   = 2,
   parameter int G_TIMEOUT          = 1024
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          cfg_wr_en,
   input  logic [G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2-1:0] cfg_wr_addr,
   input  logic [G_TAP_WIDTH-1:0]                        cfg_wr_data,
   output logic                                          cfg_wr_reject,
   input  logic                                          load_start,
   input  logic                                          reverse,
   output logic                                          busy,
   output logic                                          load_done,
   output logic                                          load_error,
   output logic                                          fir_enable,
   output logic [G_TAP_WIDTH-1:0]                        tap_dout,
   output logic                                          tap_dout_valid,
   input  logic                                          tap_dout_ready,
   input  logic                                          tap_fir_done
);
   localparam int NT = calc_num_taps(G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2);
   localparam int AW = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2;
   localparam int CW = $clog2((G_TIMEOUT > G_DISABLE_CYCLES ? G_TIMEOUT : G_DISABLE_CYCLES) + 1);
   state_t state_q, state_d;
   logic rev_q, rev_d, fir_en_q, fir_en_d, valid_q, valid_d, busy_q, busy_d;
   logic done_q, done_d, err_q, err_d, rej_q, rej_d;
   logic [AW-1:0] idx_q, idx_d, first, next_idx, rd_addr;
   logic [AW:0] tcnt_q, tcnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [G_TAP_WIDTH-1:0] dout_q, dout_d, rd_data;
   logic hs, last;
   fir_tap_loader_coef_mem #(.G_DEPTH(NT), .G_WIDTH(G_TAP_WIDTH)) u_mem (
      .clk       (clk),
      .wr_en_i   (cfg_wr_en & ~busy_q),
      .wr_addr_i (cfg_wr_addr),
      .wr_data_i (cfg_wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );
   assign hs       = valid_q & tap_dout_ready;
   // tap count is one bit wider than the index so the final compare never aliases
   assign last     = tcnt_q == (AW+1)'(NT-1);
   assign first    = rev_q ? '1 : '0;
   assign next_idx = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
   // the single read port serves the first tap while disabling and the next tap while streaming
   assign rd_addr  = state_q == ST_DISABLE ? first : next_idx;
   always_comb begin
      state_d  = state_q;
      rev_d    = rev_q;
      fir_en_d = fir_en_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      err_d    = err_q;
      idx_d    = idx_q;
      tcnt_d   = tcnt_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      done_d   = 1'b0;
      rej_d    = cfg_wr_en & busy_q;
      case (state_q)
         ST_IDLE:
            if (load_start) begin
               rev_d    = reverse;
               err_d    = 1'b0;
               busy_d   = 1'b1;
               fir_en_d = 1'b0;
               cnt_d    = '0;
               state_d  = ST_DISABLE;
            end
         ST_DISABLE:
            if (cnt_q == CW'(G_DISABLE_CYCLES-1)) begin
               fir_en_d = 1'b1;
               valid_d  = 1'b1;
               dout_d   = rd_data;
               idx_d    = first;
               tcnt_d   = '0;
               cnt_d    = '0;
               state_d  = ST_STREAM;
            end else cnt_d = cnt_q + 1'b1;
         ST_STREAM:
            // done before the final tap is accepted means the FIR and loader disagree on the tap count
            if (tap_fir_done && !(hs && last)) begin
               valid_d = 1'b0;
               state_d = ST_ERROR;
            end else if (hs) begin
               cnt_d  = '0;
               tcnt_d = tcnt_q + 1'b1;
               if (last) begin
                  valid_d = 1'b0;
                  state_d = ST_WAIT_DONE;
               end else begin
                  idx_d  = next_idx;
                  dout_d = rd_data;
               end
            end else if (cnt_q == CW'(G_TIMEOUT-1)) begin
               valid_d = 1'b0;
               state_d = ST_ERROR;
            end else cnt_d = cnt_q + 1'b1;
         ST_WAIT_DONE:
            if (tap_fir_done) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (cnt_q == CW'(G_TIMEOUT-1)) state_d = ST_ERROR;
            else cnt_d = cnt_q + 1'b1;
         ST_ERROR: begin
            fir_en_d = 1'b0;
            valid_d  = 1'b0;
            err_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state_q  <= ST_IDLE;
         rev_q    <= 1'b0;
         fir_en_q <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rej_q    <= 1'b0;
         idx_q    <= '0;
         tcnt_q   <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         rev_q    <= rev_d;
         fir_en_q <= fir_en_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rej_q    <= rej_d;
         idx_q    <= idx_d;
         tcnt_q   <= tcnt_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
      end
   assign cfg_wr_reject  = rej_q;
   assign busy           = busy_q;
   assign load_done      = done_q;
   assign load_error     = err_q;
   assign fir_enable     = fir_en_q;
   assign tap_dout       = dout_q;
   assign tap_dout_valid = valid_q;
endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: directed bench with a tap-order model and a per-cycle stream monitor.
module tb_fir_tap_loader;
   localparam int NT = 16;
   localparam int TO = 16;
   logic clk = 1'b0, reset = 1'b1;
   logic cfg_wr_en = 1'b0, load_start = 1'b0, reverse = 1'b0;
   logic tap_dout_ready = 1'b0, tap_fir_done = 1'b0;
   logic [3:0] cfg_wr_addr = '0;
   logic [15:0] cfg_wr_data = '0;
   logic cfg_wr_reject, busy, load_done, load_error, fir_enable, tap_dout_valid;
   logic [15:0] tap_dout;
   int n_chk = 0, n_err = 0, ng = 0;
   logic [15:0] model_mem [NT];
   logic [15:0] exp_q [$];
   logic [15:0] got [NT];
   logic prev_stall = 1'b0;
   logic [15:0] prev_dout = '0;
   fir_tap_loader #(.G_NUM_STAGES_LOG2(2), .G_STAGE_DEPTH_LOG2(2), .G_TAP_WIDTH(16),
                    .G_DISABLE_CYCLES(2), .G_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
      .cfg_wr_data(cfg_wr_data), .cfg_wr_reject(cfg_wr_reject), .load_start(load_start),
      .reverse(reverse), .busy(busy), .load_done(load_done), .load_error(load_error),
      .fir_enable(fir_enable), .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid),
      .tap_dout_ready(tap_dout_ready), .tap_fir_done(tap_fir_done)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // every accepted tap must be the next one the model predicts; a stalled tap must not move
   always @(negedge clk)
      if (reset) prev_stall = 1'b0;
      else begin
         if (prev_stall && tap_dout_valid) check("hold", tap_dout, prev_dout);
         if (tap_dout_valid && tap_dout_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL extra_tap: got %h expected none", tap_dout);
            end else begin
               check("tap", tap_dout, exp_q.pop_front());
               if (ng < NT) got[ng] = tap_dout;
               ng++;
            end
         end
         prev_stall = tap_dout_valid && !tap_dout_ready;
         prev_dout  = tap_dout;
      end
   task automatic write(input int a, input logic [15:0] d);
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'(a); cfg_wr_data = d;
      model_mem[a] = d;
      tick();
      cfg_wr_en = 1'b0;
   endtask
   task automatic start_load(input logic rev);
      exp_q.delete();
      for (int i = 0; i < NT; i++) exp_q.push_back(model_mem[rev ? NT-1-i : i]);
      ng = 0;
      load_start = 1'b1; reverse = rev;
      tick();
      load_start = 1'b0; cfg_wr_en = 1'b0;
      check("busy_at_start", busy, 1);
      check("err_cleared", load_error, 0);
   endtask
   task automatic run_stream(input logic tog, input int max, output int k);
      k = 0;
      while (exp_q.size() != 0 && k < max) begin
         if (tog) tap_dout_ready = ~tap_dout_ready;
         tick();
         k++;
      end
      check("stream_left", exp_q.size(), 0);
   endtask
   task automatic wait_left(input int left);
      int k = 0;
      while (exp_q.size() > left && k < 100) begin tick(); k++; end
      check("wait_left", exp_q.size(), left);
   endtask
   task automatic finish_load();
      tap_fir_done = 1'b1;
      tick();
      tap_fir_done = 1'b0;
      check("done_pulse", {load_done, busy, fir_enable, load_error}, 4'b1010);
      tick();
      check("done_single", load_done, 0);
   endtask
   task automatic expect_error_after(input int n);
      for (int i = 0; i < n; i++) tick();
      check("pre_error", {load_error, busy}, 2'b01);
      tick();
      check("error_state", {load_error, fir_enable, tap_dout_valid, busy}, 4'b1000);
      exp_q.delete();
   endtask
   initial begin
      int k, lows;
      repeat (3) tick();
      check("reset_vals", {fir_enable, tap_dout_valid, tap_dout, busy, load_done, load_error, cfg_wr_reject}, 0);
      reset = 1'b0;
      for (int i = 0; i < NT; i++) write(i, 16'h0100 + 16'(i));
      check("idle_no_reject", cfg_wr_reject, 0);
      // 1: forward, ready always high
      tap_dout_ready = 1'b1;
      start_load(1'b0);
      lows = 0;
      while (!fir_enable && lows < 20) begin lows++; tick(); end
      check("disable_cycles", lows, 2);
      run_stream(1'b0, 50, k);
      check("one_per_cycle", k, NT);
      finish_load();
      check("fwd_first", got[0], 16'h0100);
      check("fwd_last", got[15], 16'h010F);
      // 2: reverse, ready toggling
      start_load(1'b1);
      run_stream(1'b1, 100, k);
      tap_dout_ready = 1'b1;
      finish_load();
      check("rev_first", got[0], 16'h010F);
      check("rev_last", got[15], 16'h0100);
      // 3: write while busy is rejected
      start_load(1'b0);
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'd3; cfg_wr_data = 16'hBEEF;
      tick();
      cfg_wr_en = 1'b0;
      check("reject_pulse", cfg_wr_reject, 1);
      tick();
      check("reject_single", cfg_wr_reject, 0);
      run_stream(1'b0, 50, k);
      finish_load();
      // write coinciding with load_start in idle is included
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'd5; cfg_wr_data = 16'h1234;
      model_mem[5] = 16'h1234;
      start_load(1'b0);
      run_stream(1'b0, 50, k);
      finish_load();
      check("kept_mem3", got[3], 16'h0103);
      check("same_cycle_wr", got[5], 16'h1234);
      // 4: stall timeout
      tap_dout_ready = 1'b0;
      start_load(1'b0);
      k = 0;
      while (!fir_enable && k < 20) begin k++; tick(); end
      check("enable_up", fir_enable, 1);
      expect_error_after(TO);
      // 5a: all taps accepted, done never arrives
      tap_dout_ready = 1'b1;
      start_load(1'b0);
      run_stream(1'b0, 50, k);
      expect_error_after(TO);
      // 5b: done arrives early, after tap 5
      start_load(1'b0);
      wait_left(NT-5);
      tap_dout_ready = 1'b0; tap_fir_done = 1'b1;
      expect_error_after(1);
      tap_fir_done = 1'b0; tap_dout_ready = 1'b1;
      // 6: reset mid-stream, memory retained
      write(5, 16'h0105);
      start_load(1'b0);
      wait_left(NT-7);
      reset = 1'b1;
      tick();
      check("reset_abort", {fir_enable, tap_dout_valid, tap_dout, busy, load_done, load_error, cfg_wr_reject}, 0);
      exp_q.delete();
      reset = 1'b0;
      start_load(1'b0);
      run_stream(1'b0, 50, k);
      finish_load();
      check("after_rst_first", got[0], 16'h0100);
      check("after_rst_mid", got[7], 16'h0107);
      check("after_rst_last", got[15], 16'h010F);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fir_tap_loader.md
Name: fir_tap_loader

Overview:
Initiator side of the FIR tap-programming interface: holds a shadow coefficient bank and drives the FIR's enable, tap stream and done status.
- On a load request, power-cycles the FIR enable, streams exactly G_NUM_TAPS coefficients over a valid/ready handshake, then waits for the FIR's done.
- Sits between the control/register block and the configurable FIR.

Parameters:
G_NUM_STAGES_LOG2, 2, must match the FIR stage-count parameter
G_STAGE_DEPTH_LOG2, 2, must match the FIR stage-depth parameter
G_TAP_WIDTH, 16, coefficient width in bits
G_DISABLE_CYCLES, 2, cycles fir_enable is held low before streaming (minimum 1)
G_TIMEOUT, 1024, maximum cycles of stream stall or done-wait before error
(derived) G_NUM_TAPS = 2**(G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2); AW = log2(G_NUM_TAPS)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_wr_en  in  1  coefficient write strobe
cfg_wr_addr  in  AW  coefficient index
cfg_wr_data  in  G_TAP_WIDTH  coefficient value
cfg_wr_reject  out  1  one-cycle pulse: write ignored because busy
load_start  in  1  load request pulse
reverse  in  1  sampled at load_start; 1 = stream index G_NUM_TAPS-1 down to 0
busy  out  1  high from accepted load_start until DONE/ERROR exit
load_done  out  1  one-cycle pulse on successful load
load_error  out  1  sticky error flag, cleared by the next accepted load_start
fir_enable  out  1  FIR enable
tap_dout  out  G_TAP_WIDTH  coefficient to FIR
tap_dout_valid  out  1  coefficient valid
tap_dout_ready  in  1  FIR ready
tap_fir_done  in  1  FIR programming-done status

Behaviour:
- Reset values: fir_enable=0, tap_dout_valid=0, tap_dout=0, busy=0, load_done=0, load_error=0, cfg_wr_reject=0, state=ST_IDLE.
- Reset does not clear the coefficient memory.
- Reset mid-load aborts immediately to the reset values.

Coefficient memory:
- G_NUM_TAPS x G_TAP_WIDTH register array, asynchronous read.
- A write when cfg_wr_en=1 and busy=0 takes effect at that clock edge.
- cfg_wr_en while busy=1: no write; cfg_wr_reject pulses the next cycle.
- cfg_wr_en and load_start in the same idle cycle: the write is accepted and the loaded data includes it.

State machine:
- ST_IDLE:
  - fir_enable keeps its last value.
  - On load_start: latch reverse, load_error<=0, busy<=1, fir_enable<=0, clear the counter, go to ST_DISABLE.
  - load_start while busy is ignored.
- ST_DISABLE:
  - Hold for G_DISABLE_CYCLES cycles.
  - On exit: fir_enable<=1, tap_dout_valid<=1, tap_dout<=mem[first], idx<=first, go to ST_STREAM.
  - first = 0, or G_NUM_TAPS-1 when reverse=1.
- ST_STREAM:
  - A handshake is a cycle with tap_dout_valid && tap_dout_ready.
  - tap_dout is held stable while valid && !ready.
  - On a non-final handshake: idx steps by ±1 and tap_dout<=mem[next idx]. Sustains one tap per cycle.
  - On the G_NUM_TAPS-th handshake: tap_dout_valid<=0, go to ST_WAIT_DONE.
  - Stall counter counts consecutive non-handshake cycles; reaching G_TIMEOUT -> ST_ERROR.
- ST_WAIT_DONE:
  - tap_fir_done=1 -> load_done pulse, busy<=0, go to ST_IDLE with fir_enable remaining 1.
  - G_TIMEOUT cycles without done -> ST_ERROR.
- ST_ERROR (single cycle): fir_enable<=0, tap_dout_valid<=0, load_error<=1, busy<=0, go to ST_IDLE.
- Early done: tap_fir_done=1 observed in ST_STREAM before the final handshake -> ST_ERROR.
- Counters:
  - Tap count is AW+1 bits, so the final-handshake compare has no wrap ambiguity.
  - The timeout counter saturates.

Decomposition:
- Package fir_tap_loader_pkg:
  - state enum (ST_IDLE, ST_DISABLE, ST_STREAM, ST_WAIT_DONE, ST_ERROR);
  - function computing G_NUM_TAPS from the two log2 parameters.
- Sub-module fir_tap_loader_coef_mem: parameterised register array, one write port, async read port.

Test Plan:
1. Write mem[i]=i+0x100 for i=0..15; load_start, reverse=0, ready always 1 -> fir_enable low 2 cycles; tap_dout 0x100..0x10F on 16 consecutive cycles. FIR responds with done -> load_done one pulse, busy low, fir_enable=1.
2. Same data, reverse=1, ready toggling 1/0 each cycle -> sequence 0x10F..0x100; no duplicate or skipped value; tap_dout stable during every ready=0 cycle.
3. Write during busy (addr 3, data 0xBEEF) -> cfg_wr_reject pulses; a subsequent load streams mem[3]=0x103.
4. tap_dout_ready held 0 after enable, G_TIMEOUT=16 -> ST_ERROR after 16 stall cycles; load_error=1, fir_enable=0, valid=0. Next load_start clears load_error.
5. All 16 taps accepted, tap_fir_done never asserted -> load_error after 16 cycles. tap_fir_done asserted after tap 5 -> immediate error.
6. Reset asserted mid-stream (after tap 7) -> next cycle all outputs at reset values. Memory retained: a fresh load streams 0x100..0x10F.
